// File: rtl/branch_predict_unit_if.sv
// Resolve request/result bundle between issue and the branch unit.
// master drives requests, slave returns registered results.
interface branch_predict_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DISP_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_flush;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [2:0]            in_br_code;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [DATA_WIDTH-1:0] in_rs2;
  logic [DISP_WIDTH-1:0] in_disp;
  logic                  in_pred_taken;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_next_pc;
  logic                  out_taken;
  logic                  out_mispredict;

  modport master (
    output in_valid, in_flush, in_pc, in_br_code,
    output in_rs1, in_rs2, in_disp, in_pred_taken,
    input  out_valid, out_next_pc, out_taken, out_mispredict
  );

  modport slave (
    input  in_valid, in_flush, in_pc, in_br_code,
    input  in_rs1, in_rs2, in_disp, in_pred_taken,
    output out_valid, out_next_pc, out_taken, out_mispredict
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Single-stage branch resolver with a 2-bit saturating BHT
// read by fetch, misprediction flagging and perf counters.
module branch_predict_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DISP_WIDTH  = 16,
  parameter int DISP_SHIFT  = 2,
  parameter int PC_INC      = 4,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_taken,
  branch_predict_unit_if.slave  bus,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);
  localparam int IW = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE,
    BR_LTU, BR_GEU, BR_ALWAYS, BR_NONE
  } br_code_e;

  logic [1:0]            r_bht [BHT_ENTRIES];
  logic                  r_valid;
  logic                  r_taken;
  logic                  r_mis;
  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic [CNT_WIDTH-1:0]  r_br_cnt;
  logic [CNT_WIDTH-1:0]  r_mp_cnt;

  br_code_e              w_code;
  logic                  w_acc;
  logic                  w_taken;
  logic                  w_cond;
  logic                  w_mis;
  logic [IW-1:0]         w_lk_idx;
  logic [IW-1:0]         w_up_idx;
  logic [1:0]            w_cnt;
  logic [1:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_unused_pc;

  assign w_code   = br_code_e'(bus.in_br_code);
  assign w_acc    = bus.in_valid && !bus.in_flush;
  assign w_lk_idx = lookup_pc[DISP_SHIFT +: IW];
  assign w_up_idx = bus.in_pc[DISP_SHIFT +: IW];
  assign w_unused_pc = ^lookup_pc;

  assign lookup_taken = r_bht[w_lk_idx][1];

  always_comb begin
    w_taken = 1'b0;
    w_cond  = 1'b1;
    unique case (w_code)
      BR_EQ:     w_taken = bus.in_rs1 == bus.in_rs2;
      BR_NE:     w_taken = bus.in_rs1 != bus.in_rs2;
      BR_LT:     w_taken = $signed(bus.in_rs1) <  $signed(bus.in_rs2);
      BR_GE:     w_taken = $signed(bus.in_rs1) >= $signed(bus.in_rs2);
      BR_LTU:    w_taken = bus.in_rs1 <  bus.in_rs2;
      BR_GEU:    w_taken = bus.in_rs1 >= bus.in_rs2;
      BR_ALWAYS: begin w_taken = 1'b1; w_cond = 1'b0; end
      BR_NONE:   begin w_taken = 1'b0; w_cond = 1'b0; end
    endcase
  end

  assign w_seq_pc = bus.in_pc + ADDR_WIDTH'(PC_INC);
  assign w_off = {{(ADDR_WIDTH-DISP_WIDTH){bus.in_disp[DISP_WIDTH-1]}},
                  bus.in_disp} << DISP_SHIFT;
  assign w_next_pc = w_taken ? w_seq_pc + w_off : w_seq_pc;
  assign w_mis = w_taken ^ bus.in_pred_taken;

  assign w_cnt = r_bht[w_up_idx];
  always_comb begin
    w_cnt_nxt = w_cnt;
    if (w_taken && w_cnt != 2'd3)
      w_cnt_nxt = w_cnt + 2'd1;
    else if (!w_taken && w_cnt != 2'd0)
      w_cnt_nxt = w_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        r_bht[i] <= 2'b01;
    end else if (w_acc && w_cond) begin
      r_bht[w_up_idx] <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_mis     <= 1'b0;
      r_next_pc <= '0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_taken   <= w_taken;
        r_mis     <= w_mis;
        r_next_pc <= w_next_pc;
      end
    end
  end

  // counters saturate rather than wrap so long runs stay meaningful
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_acc) begin
      if (w_code != BR_NONE && r_br_cnt != '1)
        r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
      if (w_mis && r_mp_cnt != '1)
        r_mp_cnt <= r_mp_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid      = r_valid;
  assign bus.out_taken      = r_taken;
  assign bus.out_mispredict = r_mis;
  assign bus.out_next_pc    = r_next_pc;
  assign br_count           = r_br_cnt;
  assign mispred_count      = r_mp_cnt;
endmodule
